// File: rtl/ssp_rx_deframer.sv
// ssp_rx_deframer
// Receive-side SSP deframer: samples the serial line (SSPCLKIN, SSPFSSIN,
// SSPRXD) in the PCLK domain, detects frame starts on falling bit-clock edges,
// deserializes MSB-first words and buffers them in a show-ahead FIFO.
// Status: OVERRUN (sticky), FRAME_ERR (one-cycle abort pulse), FRAME_CNT.
//
// Optional build macro: SSP_RX_SYNC_EN
//   defined   - two-flop synchronizer ahead of the input registers
//               (pin-to-word latency 5 PCLK edges)
//   undefined - single input register stage for PCLK-domain sources
//               (pin-to-word latency 3 PCLK edges)

module ssp_rx_deframer #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          PCLK,
    input  logic                          CLEAR,
    input  logic                          SSPCLKIN,
    input  logic                          SSPFSSIN,
    input  logic                          SSPRXD,
    input  logic                          RD_EN,
    input  logic                          CLR_OVR,
    output logic [DATA_WIDTH-1:0]         RD_DATA,
    output logic                          RX_EMPTY,
    output logic                          RX_FULL,
    output logic [$clog2(FIFO_DEPTH):0]   RX_LEVEL,
    output logic                          OVERRUN,
    output logic                          FRAME_ERR,
    output logic [7:0]                    FRAME_CNT,
    output logic                          BUSY
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PUSH
    } state_t;

    state_t state, state_next;

    // Serial line after the optional synchronizer, packed {clk, fss, rxd}
    logic [2:0] line_in;

`ifdef SSP_RX_SYNC_EN
    logic [2:0] sync_1;
    logic [2:0] sync_2;

    // Two-flop synchronizer for line inputs arriving from another clock domain
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= {SSPCLKIN, SSPFSSIN, SSPRXD};
            sync_2 <= sync_1;
        end
    end

    assign line_in = sync_2;
`else
    assign line_in = {SSPCLKIN, SSPFSSIN, SSPRXD};
`endif

    logic s_clk;
    logic s_fss;
    logic s_rxd;
    logic s_clk_d;
    logic fall;

    // Input register stage plus delayed bit clock for fall detection
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            s_clk   <= 1'b0;
            s_fss   <= 1'b0;
            s_rxd   <= 1'b0;
            s_clk_d <= 1'b0;
        end else begin
            {s_clk, s_fss, s_rxd} <= line_in;
            s_clk_d               <= s_clk;
        end
    end

    // Data and sync are only trusted on a bit-clock falling edge, since the
    // transmitter launches on the rising edge.
    assign fall = s_clk_d & ~s_clk;

    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;

    // FSM state register
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    // NOTE: every always_comb output gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (fall && s_fss) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (fall && !s_fss && bit_cnt == CW'(DATA_WIDTH - 1)) begin
                    state_next = ST_PUSH;
                end
            end
            ST_PUSH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    logic start_frame;
    logic shift_bit;
    logic abort_frame;
    logic push_word;

    // FSM output decode: datapath strobes and BUSY
    always_comb begin
        start_frame = 1'b0;
        shift_bit   = 1'b0;
        abort_frame = 1'b0;
        push_word   = 1'b0;
        BUSY        = 1'b0;
        case (state)
            ST_IDLE: begin
                start_frame = fall & s_fss;
            end
            ST_SHIFT: begin
                BUSY        = 1'b1;
                shift_bit   = fall & ~s_fss;
                abort_frame = fall & s_fss;
            end
            ST_PUSH: begin
                BUSY      = 1'b1;
                push_word = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    // Deserializer: an early FSS restarts the bit count and drops the partial word
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (start_frame || abort_frame) begin
            bit_cnt <= '0;
        end else if (shift_bit) begin
            shreg   <= {shreg[DATA_WIDTH-2:0], s_rxd};
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

    // Abort pulse, registered so it lasts exactly one cycle
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            FRAME_ERR <= 1'b0;
        end else begin
            FRAME_ERR <= abort_frame;
        end
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;

    // A full FIFO still accepts the word when the host pops in the same cycle.
    assign pop   = RD_EN & ~RX_EMPTY;
    assign wr_en = push_word & (~RX_FULL | pop);
    assign drop  = push_word & RX_FULL & ~pop;

    // FIFO storage; cleared on reset so RD_DATA reads 0 while empty
    // NOTE: the storage array is reset here on purpose; without it RD_DATA
    // would show stale or X data when empty after CLEAR.
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
        end
    end

    // FIFO pointers with wrap bit
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Sticky overrun; a drop in the same cycle as CLR_OVR keeps it set
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            OVERRUN <= 1'b0;
        end else if (drop) begin
            OVERRUN <= 1'b1;
        end else if (CLR_OVR) begin
            OVERRUN <= 1'b0;
        end
    end

    // Completed-frame counter, including dropped words, wrapping at 255
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            FRAME_CNT <= '0;
        end else if (push_word) begin
            FRAME_CNT <= FRAME_CNT + 8'd1;
        end
    end

    assign RX_EMPTY = (wr_ptr == rd_ptr);
    assign RX_FULL  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign RX_LEVEL = wr_ptr - rd_ptr;
    assign RD_DATA  = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ssp_rx_deframer.sv
// tb_ssp_rx_deframer
// Directed and randomized stimulus for ssp_rx_deframer, compared against a
// queue-based model of the receive FIFO and status flags.
// Honors SSP_RX_SYNC_EN for the pin-to-word latency.

module tb_ssp_rx_deframer;

`ifdef SSP_RX_SYNC_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif
    localparam int DEPTH = 4;

    logic       PCLK = 1'b0;
    logic       CLEAR = 1'b1;
    logic       SSPCLKIN = 1'b0;
    logic       SSPFSSIN = 1'b0;
    logic       SSPRXD = 1'b0;
    logic       RD_EN = 1'b0;
    logic       CLR_OVR = 1'b0;
    logic [7:0] RD_DATA;
    logic       RX_EMPTY;
    logic       RX_FULL;
    logic [2:0] RX_LEVEL;
    logic       OVERRUN;
    logic       FRAME_ERR;
    logic [7:0] FRAME_CNT;
    logic       BUSY;

    ssp_rx_deframer #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
        .PCLK     (PCLK),
        .CLEAR    (CLEAR),
        .SSPCLKIN (SSPCLKIN),
        .SSPFSSIN (SSPFSSIN),
        .SSPRXD   (SSPRXD),
        .RD_EN    (RD_EN),
        .CLR_OVR  (CLR_OVR),
        .RD_DATA  (RD_DATA),
        .RX_EMPTY (RX_EMPTY),
        .RX_FULL  (RX_FULL),
        .RX_LEVEL (RX_LEVEL),
        .OVERRUN  (OVERRUN),
        .FRAME_ERR(FRAME_ERR),
        .FRAME_CNT(FRAME_CNT),
        .BUSY     (BUSY)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] q[$];
    int         m_cnt = 0;
    logic       m_ovr = 1'b0;
    int         m_ferr = 0;

    // Counts cycles with FRAME_ERR high
    int ferr_seen = 0;
    always @(negedge PCLK) begin
        if (!CLEAR && FRAME_ERR === 1'b1) ferr_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bit period at PCLK/2: rising bit clock with new data, then falling
    task automatic send_bit(input logic fss, input logic d);
        @(negedge PCLK);
        SSPCLKIN = 1'b1;
        SSPFSSIN = fss;
        SSPRXD   = d;
        @(negedge PCLK);
        SSPCLKIN = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w);
        send_bit(1'b1, 1'($urandom));
        for (int b = 7; b >= 0; b--) send_bit(1'b0, w[b]);
    endtask

    // Wait until the last sent word has reached the FIFO
    task automatic settle();
        repeat (LAT) @(posedge PCLK);
        @(negedge PCLK);
    endtask

    // Model of a completed frame landing in the FIFO
    task automatic model_push(input logic [7:0] w);
        m_cnt = (m_cnt + 1) % 256;
        if (q.size() < DEPTH) q.push_back(w);
        else m_ovr = 1'b1;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".level"}, 32'(RX_LEVEL), 32'(q.size()));
        check({tag, ".empty"}, 32'(RX_EMPTY), 32'(q.size() == 0));
        check({tag, ".full"}, 32'(RX_FULL), 32'(q.size() == DEPTH));
        check({tag, ".ovr"}, 32'(OVERRUN), 32'(m_ovr));
        check({tag, ".cnt"}, 32'(FRAME_CNT), 32'(m_cnt));
        check({tag, ".ferr"}, 32'(ferr_seen), 32'(m_ferr));
    endtask

    task automatic pop_word(input string tag);
        @(negedge PCLK);
        if (q.size() > 0) check({tag, ".data"}, 32'(RD_DATA), 32'(q[0]));
        RD_EN = 1'b1;
        @(negedge PCLK);
        RD_EN = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check({tag, ".lvl"}, 32'(RX_LEVEL), 32'(q.size()));
    endtask

    task automatic clear_ovr();
        @(negedge PCLK);
        CLR_OVR = 1'b1;
        @(negedge PCLK);
        CLR_OVR = 1'b0;
        m_ovr = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        int nf;
        int np;
        logic [7:0] burst[2];

        // Reset state
        #1;
        check("rst.data", 32'(RD_DATA), 32'h0);
        check("rst.busy", 32'(BUSY), 32'h0);
        check("rst.ferr_pin", 32'(FRAME_ERR), 32'h0);
        check_status("rst");
        repeat (3) @(negedge PCLK);
        CLEAR = 1'b0;

        // Single frame 0xA5 with latency
        send_frame(8'hA5);
        check("a5.busy", 32'(BUSY), 32'h1);
        repeat (LAT - 1) @(posedge PCLK);
        #1;
        check("a5.early_empty", 32'(RX_EMPTY), 32'h1);
        @(posedge PCLK);
        #1;
        model_push(8'hA5);
        check("a5.data", 32'(RD_DATA), 32'hA5);
        check("a5.idle", 32'(BUSY), 32'h0);
        check_status("a5");
        pop_word("a5.pop");

        // Fill, overrun, drain, clear overrun
        for (int i = 1; i <= 4; i++) begin
            w = 8'(i * 8'h11);
            send_frame(w);
            settle();
            model_push(w);
        end
        check_status("fill");
        send_frame(8'h55);
        settle();
        model_push(8'h55);
        check_status("ovr");
        for (int i = 0; i < 4; i++) pop_word("drain");
        check_status("drained");
        clear_ovr();
        check_status("clrovr");

        // Pop during PUSH of a full FIFO keeps the word
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom);
            send_frame(w);
            settle();
            model_push(w);
        end
        send_frame(8'h66);
        repeat (LAT - 1) @(posedge PCLK);
        @(negedge PCLK);
        check("pp.head", 32'(RD_DATA), 32'(q[0]));
        RD_EN = 1'b1;
        @(negedge PCLK);
        RD_EN = 1'b0;
        void'(q.pop_front());
        model_push(8'h66);
        check_status("pp");
        for (int i = 0; i < 4; i++) pop_word("pp.drain");

        // Aborted frame after 3 bits, then a good frame 0xC3
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'($urandom));
        send_frame(8'hC3);
        settle();
        m_ferr++;
        model_push(8'hC3);
        check("abort.data", 32'(RD_DATA), 32'hC3);
        check_status("abort");
        pop_word("abort.pop");

        // CLEAR mid-frame with a word already buffered
        send_frame(8'h5A);
        settle();
        model_push(8'h5A);
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'($urandom));
        @(negedge PCLK);
        CLEAR = 1'b1;
        #1;
        q.delete();
        m_cnt = 0;
        m_ovr = 1'b0;
        check("clr.data", 32'(RD_DATA), 32'h0);
        check("clr.busy", 32'(BUSY), 32'h0);
        check("clr.ferr_pin", 32'(FRAME_ERR), 32'h0);
        check_status("clr");
        repeat (2) @(negedge PCLK);
        CLEAR = 1'b0;
        send_frame(8'h7E);
        settle();
        model_push(8'h7E);
        check("clr.7e", 32'(RD_DATA), 32'h7E);
        check_status("after_clr");
        pop_word("clr.pop");

        // Pop on empty FIFO
        pop_word("empty.pop");
        check_status("empty");

        // Random frames (single or back-to-back), random pops and clears;
        // enough frames to wrap FRAME_CNT
        for (int it = 0; it < 180; it++) begin
            nf = $urandom_range(1, 2);
            for (int f = 0; f < nf; f++) begin
                burst[f] = 8'($urandom);
                send_frame(burst[f]);
            end
            settle();
            for (int f = 0; f < nf; f++) model_push(burst[f]);
            check_status("rnd");
            check("rnd.busy", 32'(BUSY), 32'h0);
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) pop_word("rnd.pop");
            if ($urandom_range(0, 3) == 0) clear_ovr();
        end
        check_status("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ssp_rx_deframer.md
# ssp_rx_deframer

Receive-side deframer that sits downstream of the SSP transmit logic. It samples the serial line triple (SSPCLKIN, SSPFSSIN, SSPRXD) in the PCLK domain, detects frame starts, and deserializes 8-bit MSB-first words. It buffers the words in a small show-ahead FIFO that a host reads with a one-cycle pop strobe. It also reports overrun, frame-abort and good-frame-count status.

## Interface
- DATA_WIDTH, 8, word width and bits per frame
- FIFO_DEPTH, 4, receive FIFO entries (power of two, ≥2)
- PCLK  in  1  system clock; all state on rising edge
- CLEAR  in  1  reset; asynchronous, active-high
- SSPCLKIN  in  1  serial bit clock (≤ PCLK/2, high and low phases ≥1 PCLK each)
- SSPFSSIN  in  1  frame sync, high for one SSPCLKIN period before bit 7
- SSPRXD  in  1  serial data, MSB first
- RD_EN  in  1  pop strobe; ignored when RX_EMPTY
- CLR_OVR  in  1  clears OVERRUN
- RD_DATA  out  DATA_WIDTH  head of FIFO (show-ahead); 0 when empty after reset
- RX_EMPTY  out  1  FIFO holds 0 words
- RX_FULL  out  1  FIFO holds FIFO_DEPTH words
- RX_LEVEL  out  $clog2(FIFO_DEPTH)+1  word count
- OVERRUN  out  1  sticky: word dropped on full FIFO
- FRAME_ERR  out  1  one-cycle pulse: frame aborted by early FSS
- FRAME_CNT  out  8  good frames pushed, wraps 255→0
- BUSY  out  1  high in SHIFT or PUSH

## Operation
- Inputs are registered once into s_clk, s_fss and s_rxd; s_clk_d holds the previous s_clk. fall = s_clk_d & ~s_clk. All sampling happens only on a fall cycle; the transmitter changes data on rising edges.
- FSM IDLE / SHIFT / PUSH, reset to IDLE.
  - IDLE: fall & s_fss → SHIFT with bit_cnt=0. Otherwise hold.
  - SHIFT: on fall with s_fss=0, shreg ← {shreg[6:0], s_rxd} and bit_cnt+1. When bit_cnt reaches 7 (8th bit), → PUSH.
  - SHIFT: on fall with s_fss=1, the frame is aborted. FRAME_ERR pulses, bit_cnt resets to 0, stay in SHIFT (resync to the new frame). The partial word is discarded.
  - PUSH: one cycle, then → IDLE. The word is written if the FIFO is not full, or if it is full and RD_EN is asserted in the same cycle (pop then push, level unchanged). Otherwise the word is dropped and OVERRUN ← 1. FRAME_CNT increments on every completed frame, including dropped ones.
- FIFO: wr/rd pointers of log2(FIFO_DEPTH)+1 bits with a wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the wrap bits differ.
  - RD_DATA = mem[rd_ptr].
- Pop on empty: no pointer change, no error.
- OVERRUN: CLR_OVR clears it. If a drop and CLR_OVR occur in the same cycle, the set wins.
- Reset values: RD_DATA 0, RX_EMPTY 1, RX_FULL 0, RX_LEVEL 0, OVERRUN 0, FRAME_ERR 0, FRAME_CNT 0, BUSY 0. Memory, shreg and bit_cnt are cleared.
- CLEAR mid-frame: the partial word is lost, the FSM returns to IDLE, and the FIFO contents are lost.

## Timing
- Edge k is the first PCLK edge that captures SSPCLKIN low after the 8th data bit. The shift occurs at edge k+1. The FIFO write occurs at edge k+2, so RX_EMPTY falls and RD_DATA is valid after edge k+2. Latency from pin to word is 3 edges.
- A pop at edge j: RD_DATA shows the next word after edge j; RX_LEVEL and the flags update at edge j.
- FRAME_ERR asserts for exactly one cycle after the edge that samples the abort.
- Back-to-back frames are sustained at SSPCLKIN = PCLK/2. PUSH completes before the next fall can arrive.

## Configuration
- SSP_RX_SYNC_EN defined: a two-flop synchronizer precedes the input registers for all three serial inputs. Pin-to-word latency becomes 5 PCLK edges; behaviour is otherwise identical.
- SSP_RX_SYNC_EN undefined: a single input register stage only, for inputs generated in the PCLK domain. Latency is 3 edges.

## Test plan
- Reset, then frame with FSS and data 0xA5 at PCLK/2 → RX_EMPTY=0, RD_DATA=0xA5, RX_LEVEL=1, FRAME_CNT=1 at edge k+2.
- Frames 0x11, 0x22, 0x33, 0x44 with no reads → RX_FULL=1, RX_LEVEL=4. A 5th frame 0x55 → OVERRUN=1, level stays 4. Four pops return 0x11..0x44. CLR_OVR → OVERRUN=0.
- FIFO full and RD_EN asserted in the PUSH cycle of 0x66 → no OVERRUN, level stays 4, final pop order ends with 0x66.
- FSS reasserted after 3 bits, then full frame 0xC3 → one FRAME_ERR pulse, FRAME_CNT +1, RD_DATA=0xC3.
- CLEAR asserted mid-frame after 5 bits, then released and frame 0x7E sent → all outputs at reset values during CLEAR, then a single word 0x7E.
- RD_EN on empty FIFO → RX_LEVEL=0, RX_EMPTY=1, no flag changes.
